// File: rtl/stego_tx_sequencer.sv
// stego_tx_sequencer: embeds message bits into frames via the bit changer and streams them LSB byte first (STEGO_SEQ_SKID_BUF_EN adds a one-deep frame buffer)
module stego_tx_sequencer #(
  parameter int BPS = 16,
  parameter int FRAME_SIZE = 1,
  parameter int MSG_LEN = 8,
  parameter int BC_TIMEOUT = 64
) (
  input  logic                       in_clk,
  input  logic                       in_rst,
  input  logic                       in_sample_ready,
  input  logic [FRAME_SIZE*BPS-1:0]  in_sample,
  input  logic                       in_msg_load,
  input  logic [MSG_LEN-1:0]         in_msg,
  output logic                       out_bc_enable,
  output logic [FRAME_SIZE*BPS-1:0]  out_bc_frame,
  output logic [FRAME_SIZE-1:0]      out_bc_message,
  input  logic                       in_bc_ready,
  input  logic [FRAME_SIZE*BPS-1:0]  in_bc_frame,
  output logic                       out_tx_dv,
  output logic [7:0]                 out_tx_byte,
  input  logic                       in_tx_done,
  output logic                       out_busy,
  output logic                       out_msg_done,
  output logic                       out_overrun,
  output logic                       out_error
);
  localparam int FW = FRAME_SIZE*BPS;
  localparam int NB = FW/8;
  localparam int KW = NB > 1 ? $clog2(NB) : 1;
  localparam int CW = $clog2(MSG_LEN+1);
  localparam int TW = $clog2(BC_TIMEOUT+1);
  typedef enum logic [2:0] {IDLE, EMBED, WAIT_BC, TX_START, TX_WAIT} state_t;
  state_t state;
  logic [FW-1:0] frame;
  logic [MSG_LEN-1:0] msg_sr;
  logic [CW-1:0] bit_cnt;
  logic [KW-1:0] k;
  logic [TW-1:0] to_cnt;
  logic buf_valid;
  logic [FW-1:0] buf_frame;
  logic load_ok, last_done, start_new, buf_take, drop;
  logic [MSG_LEN-1:0] cur_msg;
  logic [CW-1:0] cur_cnt;
  logic [FW-1:0] new_frame;
`ifdef STEGO_SEQ_SKID_BUF_EN
  localparam bit BUF_EN = 1'b1;
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      buf_valid <= 1'b0;
      buf_frame <= '0;
    end else if (buf_take) begin
      buf_valid <= 1'b1;
      buf_frame <= in_sample;
    end else if (start_new) begin
      buf_valid <= 1'b0;
    end
  end
`else
  localparam bit BUF_EN = 1'b0;
  assign buf_valid = 1'b0;
  assign buf_frame = '0;
`endif
  always_comb begin
    load_ok = state == IDLE && in_msg_load;
    cur_msg = load_ok ? in_msg : msg_sr;
    cur_cnt = load_ok ? '0 : bit_cnt;
    last_done = state == TX_WAIT && in_tx_done && int'(k) == NB-1;
    start_new = (state == IDLE && (in_sample_ready || buf_valid)) || (last_done && buf_valid);
    new_frame = buf_valid ? buf_frame : in_sample;
    buf_take = BUF_EN && in_sample_ready && !(state == IDLE && !buf_valid) && (!buf_valid || start_new);
    drop = in_sample_ready && !(state == IDLE && !buf_valid) && !buf_take;
  end
  assign out_busy = state != IDLE;
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state <= IDLE;
      frame <= '0;
      msg_sr <= '0;
      bit_cnt <= CW'(MSG_LEN);
      k <= '0;
      to_cnt <= '0;
      out_bc_enable <= 1'b0;
      out_bc_frame <= '0;
      out_bc_message <= '0;
      out_tx_dv <= 1'b0;
      out_tx_byte <= '0;
      out_msg_done <= 1'b0;
      out_overrun <= 1'b0;
      out_error <= 1'b0;
    end else begin
      out_bc_enable <= 1'b0;
      out_tx_dv <= 1'b0;
      out_msg_done <= 1'b0;
      out_error <= 1'b0;
      if (drop) out_overrun <= 1'b1;
      if (load_ok) begin
        msg_sr <= in_msg;
        bit_cnt <= '0;
      end
      if (start_new) begin
        frame <= new_frame;
        k <= '0;
        if (cur_cnt < CW'(MSG_LEN)) begin
          state <= EMBED;
          out_bc_enable <= 1'b1;
          out_bc_frame <= new_frame;
          out_bc_message <= cur_msg[FRAME_SIZE-1:0];
        end else begin
          state <= TX_START;
          out_tx_dv <= 1'b1;
          out_tx_byte <= new_frame[7:0];
        end
      end else begin
        case (state)
          EMBED: begin
            to_cnt <= '0;
            state <= WAIT_BC;
          end
          WAIT_BC: begin
            if (in_bc_ready) begin
              frame <= in_bc_frame;
              msg_sr <= msg_sr >> FRAME_SIZE;
              bit_cnt <= bit_cnt + CW'(FRAME_SIZE);
              out_msg_done <= (bit_cnt + CW'(FRAME_SIZE)) == CW'(MSG_LEN);
              k <= '0;
              to_cnt <= '0;
              out_tx_dv <= 1'b1;
              out_tx_byte <= in_bc_frame[7:0];
              state <= TX_START;
            end else if (to_cnt == TW'(BC_TIMEOUT-1)) begin
              to_cnt <= '0;
              out_error <= 1'b1;
              state <= IDLE;
            end else begin
              to_cnt <= to_cnt + TW'(1);
            end
          end
          TX_START: state <= TX_WAIT;
          TX_WAIT: begin
            if (last_done) begin
              state <= IDLE;
            end else if (in_tx_done) begin
              k <= k + KW'(1);
              out_tx_byte <= frame[8*(int'(k)+1) +: 8];
              out_tx_dv <= 1'b1;
              state <= TX_START;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_stego_tx_sequencer.sv
// tb_stego_tx_sequencer: table vectors, corner sequences and a bit-queue model driving random frames
module tb_stego_tx_sequencer;
  logic in_clk, in_rst, in_sample_ready, in_msg_load, in_bc_ready, in_tx_done;
  logic [15:0] in_sample, in_bc_frame, out_bc_frame;
  logic [7:0] in_msg, out_tx_byte;
  logic out_bc_enable, out_tx_dv, out_busy, out_msg_done, out_overrun, out_error;
  logic [0:0] out_bc_message;
  int n_chk = 0;
  int n_fail = 0;
  bit msg_q[$];
  typedef struct {
    logic ld;
    logic [7:0] msg;
    logic [15:0] f;
    logic [15:0] r;
    logic emb;
    logic mb;
    logic done;
    logic [7:0] b0;
    logic [7:0] b1;
  } vec_t;
  vec_t vt[9];
  stego_tx_sequencer dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_sample_ready(in_sample_ready), .in_sample(in_sample),
    .in_msg_load(in_msg_load), .in_msg(in_msg), .out_bc_enable(out_bc_enable), .out_bc_frame(out_bc_frame),
    .out_bc_message(out_bc_message), .in_bc_ready(in_bc_ready), .in_bc_frame(in_bc_frame),
    .out_tx_dv(out_tx_dv), .out_tx_byte(out_tx_byte), .in_tx_done(in_tx_done), .out_busy(out_busy),
    .out_msg_done(out_msg_done), .out_overrun(out_overrun), .out_error(out_error)
  );
  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic cyc();
    @(posedge in_clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic run_frame(input logic [15:0] f, input logic [15:0] r, input bit ld, input logic [7:0] msg,
      input bit e_emb, input bit e_bit, input bit e_done, input logic [15:0] e_bytes,
      input int bc_dly, input int tx_dly);
    int n;
    in_sample = f;
    in_sample_ready = 1'b1;
    in_msg_load = ld;
    in_msg = msg;
    cyc();
    in_sample_ready = 1'b0;
    in_msg_load = 1'b0;
    check("busy_accept", out_busy, 1);
    check("bc_enable", out_bc_enable, e_emb);
    if (e_emb) begin
      check("bc_message", out_bc_message, e_bit);
      check("bc_frame", out_bc_frame, f);
      cyc();
      check("bc_enable_one_cycle", out_bc_enable, 0);
      if (bc_dly < 0) begin
        n = 1;
        while (out_error !== 1'b1 && n < 100) begin
          cyc();
          n++;
        end
        check("timeout_seen", out_error, 1);
        check("timeout_cycles", n >= 64 && n <= 65, 1);
        check("idle_after_timeout", {out_busy, out_tx_dv}, 0);
        cyc();
        check("error_pulse", out_error, 0);
        return;
      end
      repeat (bc_dly) cyc();
      check("bc_frame_held", out_bc_frame, f);
      in_bc_ready = 1'b1;
      in_bc_frame = r;
      cyc();
      in_bc_ready = 1'b0;
      check("msg_done", out_msg_done, e_done);
    end else begin
      check("msg_done_bypass", out_msg_done, 0);
    end
    for (int j = 0; j < 2; j++) begin
      check("tx_dv", out_tx_dv, 1);
      check("tx_byte", out_tx_byte, e_bytes[8*j +: 8]);
      cyc();
      check("tx_dv_pulse", out_tx_dv, 0);
      in_msg_load = 1'b1;
      in_msg = 8'h5A;
      in_bc_ready = 1'b1;
      repeat (tx_dly) cyc();
      in_msg_load = 1'b0;
      in_bc_ready = 1'b0;
      check("tx_byte_hold", out_tx_byte, e_bytes[8*j +: 8]);
      in_tx_done = 1'b1;
      cyc();
      in_tx_done = 1'b0;
    end
    check("idle_after_tx", {out_busy, out_tx_dv, out_bc_enable}, 0);
  endtask
  initial begin
    bit ld, emb, to;
    logic [7:0] m;
    logic [15:0] f, r;
    vt[0] = '{1'b1, 8'hA5, 16'h3FFF, 16'h3FFE, 1'b1, 1'b1, 1'b0, 8'hFE, 8'h3F};
    vt[1] = '{1'b0, 8'h00, 16'h1234, 16'h5678, 1'b1, 1'b0, 1'b0, 8'h78, 8'h56};
    vt[2] = '{1'b0, 8'h00, 16'hABCD, 16'hABCC, 1'b1, 1'b1, 1'b0, 8'hCC, 8'hAB};
    vt[3] = '{1'b0, 8'h00, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00};
    vt[4] = '{1'b0, 8'h00, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0, 1'b0, 8'hFE, 8'hFF};
    vt[5] = '{1'b0, 8'h00, 16'h8001, 16'h8001, 1'b1, 1'b1, 1'b0, 8'h01, 8'h80};
    vt[6] = '{1'b0, 8'h00, 16'hC3C3, 16'h3C3C, 1'b1, 1'b0, 1'b0, 8'h3C, 8'h3C};
    vt[7] = '{1'b0, 8'h00, 16'h7E81, 16'h7E80, 1'b1, 1'b1, 1'b1, 8'h80, 8'h7E};
    vt[8] = '{1'b0, 8'h00, 16'h01F0, 16'hDEAD, 1'b0, 1'b0, 1'b0, 8'hF0, 8'h01};
    in_rst = 1'b1;
    {in_sample_ready, in_msg_load, in_bc_ready, in_tx_done} = '0;
    in_sample = '0;
    in_msg = '0;
    in_bc_frame = '0;
    repeat (3) cyc();
    check("reset_outputs", {out_bc_enable, out_bc_frame, out_bc_message, out_tx_dv, out_tx_byte,
                            out_busy, out_msg_done, out_overrun, out_error}, 0);
    in_rst = 1'b0;
    cyc();
    check("idle_after_reset", out_busy, 0);
    for (int i = 0; i < 9; i++)
      run_frame(vt[i].f, vt[i].r, vt[i].ld, vt[i].msg, vt[i].emb, vt[i].mb, vt[i].done,
                {vt[i].b1, vt[i].b0}, i % 3, (i + 1) % 3);
    in_sample = 16'hBEEF;
    in_sample_ready = 1'b1;
    cyc();
    in_sample_ready = 1'b0;
    check("ovr_first_byte", {out_tx_dv, out_tx_byte}, {1'b1, 8'hEF});
    cyc();
    in_sample = 16'hCAFE;
    in_sample_ready = 1'b1;
    cyc();
    in_sample_ready = 1'b0;
`ifdef STEGO_SEQ_SKID_BUF_EN
    check("overrun_buffered", out_overrun, 0);
`else
    check("overrun_dropped", out_overrun, 1);
`endif
    in_tx_done = 1'b1;
    cyc();
    in_tx_done = 1'b0;
    check("ovr_second_byte", {out_tx_dv, out_tx_byte}, {1'b1, 8'hBE});
    cyc();
    in_tx_done = 1'b1;
    cyc();
    in_tx_done = 1'b0;
`ifdef STEGO_SEQ_SKID_BUF_EN
    check("buf_first_byte", {out_tx_dv, out_tx_byte}, {1'b1, 8'hFE});
    cyc();
    in_tx_done = 1'b1;
    cyc();
    in_tx_done = 1'b0;
    check("buf_second_byte", {out_tx_dv, out_tx_byte}, {1'b1, 8'hCA});
    cyc();
    in_tx_done = 1'b1;
    cyc();
    in_tx_done = 1'b0;
    check("buf_overrun_clear", out_overrun, 0);
`else
    check("overrun_sticky", out_overrun, 1);
`endif
    check("ovr_idle", out_busy, 0);
    in_sample = 16'h1357;
    in_sample_ready = 1'b1;
    cyc();
    in_sample_ready = 1'b0;
    cyc();
    check("rst_pre_txwait", {out_busy, out_tx_dv}, {1'b1, 1'b0});
    in_rst = 1'b1;
    cyc();
    in_rst = 1'b0;
    check("rst_abort", {out_busy, out_tx_dv, out_tx_byte, out_overrun, out_bc_enable}, 0);
    in_tx_done = 1'b1;
    cyc();
    in_tx_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("late_tx_done", {out_busy, out_tx_dv}, 0);
      cyc();
    end
    in_bc_ready = 1'b1;
    cyc();
    in_bc_ready = 1'b0;
    check("stray_bc_ready", {out_busy, out_tx_dv}, 0);
    run_frame(16'h1111, 16'h0000, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 16'h0000, -1, 0);
    run_frame(16'h2222, 16'h2223, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h2223, 2, 1);
    run_frame(16'h3333, 16'h3332, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h3332, 0, 0);
    for (int n = 0; n < 40; n++) begin
      ld = n == 0 || $urandom_range(0, 3) == 0;
      m = 8'($urandom_range(0, 255));
      f = 16'($urandom_range(0, 65535));
      r = f ^ 16'($urandom_range(0, 65535));
      if (ld) begin
        msg_q.delete();
        for (int b = 0; b < 8; b++) msg_q.push_back(m[b]);
      end
      emb = msg_q.size() > 0;
      to = emb && $urandom_range(0, 7) == 0;
      run_frame(f, r, ld, m, emb, emb ? msg_q[0] : 1'b0, msg_q.size() == 1, emb ? r : f,
                to ? -1 : int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
      if (emb && !to) void'(msg_q.pop_front());
      repeat ($urandom_range(0, 3)) begin
        in_bc_ready = 1'($urandom_range(0, 1));
        in_tx_done = 1'($urandom_range(0, 1));
        cyc();
        {in_bc_ready, in_tx_done} = '0;
        check("idle_gap", {out_busy, out_tx_dv, out_bc_enable}, 0);
      end
    end
    check("no_overrun_random", out_overrun, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stego_tx_sequencer.md
STEGO_TX_SEQUENCER -- requirements
Module: stego_tx_sequencer

Interface
REQ-001 SHALL have parameter BPS, 16, bits per sample.
REQ-002 SHALL have parameter FRAME_SIZE, 1, samples per frame and message bits embedded per frame; FRAME_SIZE*BPS a multiple of 8.
REQ-003 SHALL have parameter MSG_LEN, 8, message register width; a multiple of FRAME_SIZE.
REQ-004 SHALL have parameter BC_TIMEOUT, 64, max cycles waiting for bit changer ready.
REQ-005 in_clk  input  1  single clock, all logic on rising edge.
REQ-006 in_rst  input  1  synchronous, active-high reset.
REQ-007 in_sample_ready  input  1  one-cycle pulse, new frame from uart2sample.
REQ-008 in_sample  input  FRAME_SIZE*BPS  frame, valid with in_sample_ready.
REQ-009 in_msg_load  input  1  load message pulse.
REQ-010 in_msg  input  MSG_LEN  message bits, LSB consumed first.
REQ-011 out_bc_enable  output  1  one-cycle start pulse to bit changer.
REQ-012 out_bc_frame  output  FRAME_SIZE*BPS  frame to bit changer, held while waiting.
REQ-013 out_bc_message  output  FRAME_SIZE  message bits to bit changer, held while waiting.
REQ-014 in_bc_ready  input  1  bit changer result valid pulse.
REQ-015 in_bc_frame  input  FRAME_SIZE*BPS  modified frame, valid with in_bc_ready.
REQ-016 out_tx_dv  output  1  one-cycle byte strobe to UART transmitter.
REQ-017 out_tx_byte  output  8  byte to transmit, held until in_tx_done.
REQ-018 in_tx_done  input  1  transmitter byte complete pulse.
REQ-019 out_busy  output  1  high whenever state is not IDLE.
REQ-020 out_msg_done  output  1  one-cycle pulse when last message bits consumed.
REQ-021 out_overrun  output  1  sticky, a frame was dropped.
REQ-022 out_error  output  1  one-cycle pulse on bit changer timeout.

Function
REQ-023 States SHALL be IDLE, EMBED, WAIT_BC, TX_START, TX_WAIT.
REQ-024 IDLE: in_sample_ready latches frame; message remaining -> EMBED, message exhausted or never loaded -> TX_START with latched frame unmodified (bypass).
REQ-025 EMBED: out_bc_enable=1 for exactly one cycle (cycle after sample accept) with out_bc_message = msg_sr[FRAME_SIZE-1:0]; -> WAIT_BC.
REQ-026 WAIT_BC: on in_bc_ready capture in_bc_frame, shift msg_sr right by FRAME_SIZE, advance bit counter by FRAME_SIZE; -> TX_START.
REQ-027 When bit counter reaches MSG_LEN on capture, out_msg_done SHALL pulse same cycle as transition to TX_START.
REQ-028 WAIT_BC: after BC_TIMEOUT cycles without in_bc_ready, pulse out_error, discard frame, leave msg_sr and counter unchanged, -> IDLE.
REQ-029 TX_START: out_tx_dv=1 one cycle, out_tx_byte = byte index k of frame, k=0 first (LSB byte first); -> TX_WAIT.
REQ-030 TX_WAIT: on in_tx_done, k < FRAME_SIZE*BPS/8-1 -> increment k, TX_START; else -> IDLE (or EMBED/bypass per REQ-024 if buffered frame pending).
REQ-031 in_msg_load SHALL be accepted only in IDLE: msg_sr<=in_msg, counter<=0; ignored otherwise.
REQ-032 Simultaneous in_msg_load and in_sample_ready in IDLE: load applies first; frame embeds new in_msg bits.
REQ-033 in_sample_ready outside IDLE with no storage available: frame dropped, out_overrun<=1.
REQ-034 in_bc_ready outside WAIT_BC and in_tx_done outside TX_WAIT SHALL be ignored.

Reset
REQ-035 in_rst SHALL force IDLE, all strobes/flags/outputs 0, msg_sr 0, counter at MSG_LEN (message exhausted), buffer empty, timeout counter 0.
REQ-036 Reset mid-operation SHALL abort within one cycle; no further out_tx_dv or out_bc_enable until a new frame.

Configuration
REQ-037 Macro STEGO_SEQ_SKID_BUF_EN defined: one-deep frame buffer captures a frame arriving outside IDLE; processed immediately after current frame; overrun only when buffer already full.
REQ-038 Macro undefined: no buffer; every frame arriving outside IDLE dropped per REQ-033.

Verification
REQ-039 Reset asserted 3 cycles -> all outputs 0, out_busy 0.
REQ-040 Load 8'hA5, frame 16'h3FFF, model returns 16'h3FFE -> enable pulse with message 1'b1, then tx bytes 8'hFE, 8'h3F.
REQ-041 Eight frames after load 8'hA5 -> messages 1,0,1,0,0,1,0,1, out_msg_done on 8th; 9th frame 16'h01F0 -> no enable, tx 8'hF0, 8'h01.
REQ-042 Frame during TX_WAIT -> macro defined: sent after current, overrun 0; undefined: dropped, overrun 1.
REQ-043 Model never asserts in_bc_ready -> out_error at cycle 64 of WAIT_BC, IDLE, next frame reuses same message bit.
REQ-044 in_rst in TX_WAIT -> IDLE next cycle; late in_tx_done produces no out_tx_dv.
